// File: rtl/systolic_seq_ctrl_pkg.sv
// Shared types and constants for the boolean systolic array sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package systolic_seq_ctrl_pkg;

  // Job phases: wait for start, stream operands, flush the skew and grid, read out rows.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam int N_DEF  = 8;
  localparam int KW_DEF = 4;

  // Each grid row costs two cycles: the operand wavefront must cross 2N-1 cells,
  // and the readout chain holds two registers (accumulator + out1) per row.
  localparam int FLUSH_CYC_DEF = 2 * N_DEF;
  localparam int DRAIN_CYC_DEF = 2 * N_DEF;

  // Width of a counter/index that must hold values 0..n-1 (never below 1 bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/skew_line.sv
// One lane of the diagonal input skew: a 1-bit shift chain with a registered output.
// Latency: DEPTH+1 cycles from d_i to q_o.
// Backpressure: none; shifts every cycle.
module skew_line #(
  parameter int DEPTH = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  // Stage 0 is the output register for lane 0; further stages add one cycle each.
  logic [DEPTH:0] sr_q;

  // Shift the lane one stage per cycle; reset clears any in-flight operand bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q[0] <= d_i;
      for (int k = 1; k <= DEPTH; k++) begin
        sr_q[k] <= sr_q[k-1];
      end
    end
  end

  assign q_o = sr_q[DEPTH];

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for the NxN OR-of-AND systolic array: skewed operand feed, flush, row readout.
// Latency: push at t reaches arr_in*[j] at t+1+j; rows emerge 2N+1.. cycles after the last operand.
// Backpressure: op_ready high only in FEED; result stream has no backpressure.
module systolic_seq_ctrl
  import systolic_seq_ctrl_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int KW        = KW_DEF,
  parameter int FLUSH_CYC = 2 * N
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [KW-1:0]       k_len,
  input  logic [N-1:0]        a_vec,
  input  logic [N-1:0]        b_vec,
  input  logic                op_valid,
  output logic                op_ready,
  output logic [N-1:0]        arr_in1,
  output logic [N-1:0]        arr_in2,
  output logic                arr_readout,
  input  logic [N-1:0]        arr_out,
  output logic [N-1:0]        res_row,
  output logic [idx_w(N)-1:0] res_idx,
  output logic                res_valid,
  output logic                busy,
  output logic                done
);

  localparam int DRAIN_CYC = 2 * N;
  localparam int IW        = idx_w(N);
  localparam int CW        = idx_w((FLUSH_CYC > DRAIN_CYC) ? FLUSH_CYC : DRAIN_CYC);

  state_e          state_q, state_d;
  logic [KW-1:0]   k_len_q, k_len_d;
  logic [KW-1:0]   kcnt_q, kcnt_d;
  logic [KW-1:0]   kcnt_inc;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic [N-1:0]    res_row_q, res_row_d;
  logic [IW-1:0]   res_idx_q, res_idx_d;
  logic            res_valid_q, res_valid_d;
  logic            done_q, done_d;

  logic            beat;
  logic [N-1:0]    push_a;
  logic [N-1:0]    push_b;
  logic [N-1:0]    skew_a;
  logic [N-1:0]    skew_b;

  // A beat only exists in FEED; every other cycle pushes a zero bubble so the
  // skew drains naturally and stays aligned across bubbles and job boundaries.
  assign beat     = (state_q == ST_FEED) && op_valid;
  assign push_a   = beat ? a_vec : '0;
  assign push_b   = beat ? b_vec : '0;
  assign kcnt_inc = kcnt_q + KW'(1);

  // Lane j of each operand is delayed j extra stages so row/column wavefronts meet diagonally.
  for (genvar j = 0; j < N; j++) begin : g_lane
    skew_line #(.DEPTH(j)) u_skew_a (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (push_a[j]),
      .q_o   (skew_a[j])
    );
    skew_line #(.DEPTH(j)) u_skew_b (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (push_b[j]),
      .q_o   (skew_b[j])
    );
  end

  // Next-state and result capture: FEED counts beats, FLUSH times out the wavefront,
  // DRAIN picks the accumulator half of the alternating bottom-row stream.
  always_comb begin
    state_d     = state_q;
    k_len_d     = k_len_q;
    kcnt_d      = kcnt_q;
    cyc_d       = cyc_q;
    res_row_d   = res_row_q;
    res_idx_d   = res_idx_q;
    res_valid_d = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          k_len_d = k_len;
          kcnt_d  = '0;
          cyc_d   = '0;
          state_d = (k_len == '0) ? ST_FLUSH : ST_FEED;
        end
      end

      ST_FEED: begin
        if (op_valid) begin
          kcnt_d = kcnt_inc;
          if (kcnt_inc == k_len_q) begin
            state_d = ST_FLUSH;
          end
        end
      end

      ST_FLUSH: begin
        if (cyc_q == CW'(FLUSH_CYC - 1)) begin
          cyc_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end

      ST_DRAIN: begin
        // Odd drain cycles present an accumulator on the bottom row; even ones
        // present the stale out1 register sitting between two accumulators.
        if (cyc_q[0]) begin
          res_row_d   = arr_out;
          res_idx_d   = IW'(N - 1) - IW'(cyc_q >> 1);
          res_valid_d = 1'b1;
        end
        if (cyc_q == CW'(DRAIN_CYC - 1)) begin
          cyc_d   = '0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any job without emitting results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      k_len_q     <= '0;
      kcnt_q      <= '0;
      cyc_q       <= '0;
      res_row_q   <= '0;
      res_idx_q   <= '0;
      res_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_len_q     <= k_len_d;
      kcnt_q      <= kcnt_d;
      cyc_q       <= cyc_d;
      res_row_q   <= res_row_d;
      res_idx_q   <= res_idx_d;
      res_valid_q <= res_valid_d;
      done_q      <= done_d;
    end
  end

  // During readout the top/left edges must inject zeros so the shifted-out
  // accumulators are refilled with zero, leaving the grid clean for the next job.
  assign arr_in1     = (state_q == ST_DRAIN) ? '0 : skew_a;
  assign arr_in2     = (state_q == ST_DRAIN) ? '0 : skew_b;
  assign arr_readout = (state_q == ST_DRAIN);
  assign op_ready    = (state_q == ST_FEED);
  assign busy        = (state_q != ST_IDLE);
  assign res_row     = res_row_q;
  assign res_idx     = res_idx_q;
  assign res_valid   = res_valid_q;
  assign done        = done_q;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Bench for systolic_seq_ctrl: a behavioural NxN boolean cell grid closes the loop
// between the array lanes and arr_out; directed jobs compare emitted rows to a table.
// Jobs run back to back; a reset abort sequence follows the table.
module tb_systolic_seq_ctrl;
  import systolic_seq_ctrl_pkg::*;

  localparam int N  = N_DEF;
  localparam int KW = KW_DEF;
  localparam int IW = idx_w(N_DEF);

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [KW-1:0] k_len;
  logic [N-1:0]  a_vec;
  logic [N-1:0]  b_vec;
  logic          op_valid;
  logic          op_ready;
  logic [N-1:0]  arr_in1;
  logic [N-1:0]  arr_in2;
  logic          arr_readout;
  logic [N-1:0]  arr_out;
  logic [N-1:0]  res_row;
  logic [IW-1:0] res_idx;
  logic          res_valid;
  logic          busy;
  logic          done;

  systolic_seq_ctrl #(.N(N), .KW(KW), .FLUSH_CYC(FLUSH_CYC_DEF)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .k_len       (k_len),
    .a_vec       (a_vec),
    .b_vec       (b_vec),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .arr_in1     (arr_in1),
    .arr_in2     (arr_in2),
    .arr_readout (arr_readout),
    .arr_out     (arr_out),
    .res_row     (res_row),
    .res_idx     (res_idx),
    .res_valid   (res_valid),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural cell grid ----------------
  // Cell (i,j): in1 flows down column j, in2 flows right along row i.
  // Compute mode: acc |= in1 & in2, out1 <= in1, out2 <= in2.
  // Readout mode: acc <= in1 (from above), out1 <= acc -> 2N-deep chain per column.
  logic [N-1:0] acc_r [N];
  logic [N-1:0] o1_r  [N];
  logic [N-1:0] o2_r  [N];
  logic [N-1:0] in1_w [N];
  logic [N-1:0] in2_w [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      in1_w[i] = (i == 0) ? arr_in1 : o1_r[(i == 0) ? 0 : i - 1];
      in2_w[i] = {o2_r[i][N-2:0], arr_in2[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        acc_r[i] <= '0;
        o1_r[i]  <= '0;
        o2_r[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        o2_r[i] <= in2_w[i];
        if (arr_readout) begin
          acc_r[i] <= in1_w[i];
          o1_r[i]  <= acc_r[i];
        end else begin
          acc_r[i] <= acc_r[i] | (in1_w[i] & in2_w[i]);
          o1_r[i]  <= in1_w[i];
        end
      end
    end
  end

  assign arr_out = o1_r[N-1];

  // ---------------- result monitor ----------------
  int q_idx[$];
  int q_row[$];
  int done_cnt;
  int done_bad;

  always @(negedge clk) begin
    if (rst_n) begin
      if (res_valid) begin
        q_idx.push_back(int'(res_idx));
        q_row.push_back(int'(res_row));
      end
      if (done) begin
        done_cnt = done_cnt + 1;
        if (!res_valid || res_idx != '0 || busy) done_bad = done_bad + 1;
      end
    end
  end

  // ---------------- checking ----------------
  int checks;
  int failures;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] out_snapshot();
    return {3'b0, busy, op_ready, arr_readout, res_valid, done,
            arr_in1, arr_in2, res_row, {(8-IW){1'b0}}, res_idx};
  endfunction

  typedef struct packed {
    logic [3:0]       k;
    logic             bub;  // op_valid low on every other cycle
    logic             inj;  // pulse start while the job is running
    logic [14:0][7:0] a;
    logic [14:0][7:0] b;
    logic [7:0][7:0]  exp;  // exp[i] = expected row i
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  task automatic clear_mon();
    q_idx.delete();
    q_row.delete();
    done_cnt = 0;
    done_bad = 0;
  endtask

  task automatic run_job(input vec_t v, input int id);
    int   beat;
    int   cyc;
    int   bnd;
    logic rdy_bad;
    clear_mon();
    @(posedge clk); #1;
    start = 1'b1;
    k_len = v.k;
    @(posedge clk); #1;
    start = 1'b0;
    beat    = 0;
    cyc     = 0;
    rdy_bad = 1'b0;
    while (beat < int'(v.k) && cyc < 64) begin
      op_valid = !(v.bub && cyc[0]);
      a_vec    = op_valid ? v.a[beat] : 8'hFF;
      b_vec    = op_valid ? v.b[beat] : 8'hFF;
      @(negedge clk);
      if (!op_ready) rdy_bad = 1'b1;
      if (op_valid && op_ready) beat++;
      @(posedge clk); #1;
      cyc++;
    end
    op_valid = 1'b0;
    a_vec    = '0;
    b_vec    = '0;
    @(negedge clk);
    check($sformatf("job%0d_busy", id), 32'(busy), 32'd1);
    if (v.k != 4'd0) begin
      check($sformatf("job%0d_beats", id), beat, 32'(v.k));
      check($sformatf("job%0d_ready_in_feed", id), 32'(rdy_bad), 32'd0);
      check($sformatf("job%0d_ready_drop", id), 32'(op_ready), 32'd0);
    end
    if (v.inj) begin
      @(posedge clk); #1;
      start = 1'b1;
      k_len = 4'd5;
      @(posedge clk); #1;
      start = 1'b0;
    end
    bnd = 0;
    while (done_cnt == 0 && bnd < 200) begin
      @(negedge clk); #1;
      bnd++;
    end
    repeat (3) @(negedge clk);
    #1;
    check($sformatf("job%0d_done_count", id), done_cnt, 32'd1);
    check($sformatf("job%0d_done_align", id), done_bad, 32'd0);
    check($sformatf("job%0d_row_count", id), q_idx.size(), 32'd8);
    for (int r = 0; r < 8; r++) begin
      if (r < q_idx.size())
        check($sformatf("job%0d_res%0d", id, r),
              32'((q_idx[r] << 8) | q_row[r]), 32'(((7 - r) << 8) | int'(v.exp[7 - r])));
      else
        check($sformatf("job%0d_res%0d_missing", id, r), 32'hDEAD, 32'(((7 - r) << 8) | int'(v.exp[7 - r])));
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    k_len    = '0;
    a_vec    = '0;
    b_vec    = '0;
    op_valid = 1'b0;
    clear_mon();

    // Vector table: identity, all-ones (+ ignored start), single pair right after,
    // identity with bubbles, empty job, mixed pattern, maximum k.
    for (int v = 0; v < NV; v++) vecs[v] = '0;
    vecs[0].k = 4'd8;
    for (int k = 0; k < 8; k++) begin
      vecs[0].a[k]   = 8'(1 << k);
      vecs[0].b[k]   = 8'(1 << k);
      vecs[0].exp[k] = 8'(1 << k);
    end
    vecs[1].k    = 4'd1;
    vecs[1].inj  = 1'b1;
    vecs[1].a[0] = 8'hFF;
    vecs[1].b[0] = 8'hFF;
    for (int i = 0; i < 8; i++) vecs[1].exp[i] = 8'hFF;
    vecs[2].k      = 4'd1;
    vecs[2].a[0]   = 8'h01;
    vecs[2].b[0]   = 8'h01;
    vecs[2].exp[0] = 8'h01;
    vecs[3]     = vecs[0];
    vecs[3].bub = 1'b1;
    vecs[4].k   = 4'd0;
    vecs[5].k      = 4'd2;
    vecs[5].a[0]   = 8'h0F;
    vecs[5].b[0]   = 8'h03;
    vecs[5].a[1]   = 8'hF0;
    vecs[5].b[1]   = 8'h80;
    vecs[5].exp[0] = 8'h0F;
    vecs[5].exp[1] = 8'h0F;
    vecs[5].exp[7] = 8'hF0;
    vecs[6].k = 4'd15;
    for (int k = 0; k < 15; k++) begin
      vecs[6].a[k] = 8'(1 << (k % 8));
      vecs[6].b[k] = 8'(1 << (k % 8));
    end
    for (int i = 0; i < 8; i++) vecs[6].exp[i] = 8'(1 << i);

    #3;
    check("reset_outputs", out_snapshot(), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int v = 0; v < NV; v++) run_job(vecs[v], v);

    // Abort mid-FEED after three accepted beats.
    clear_mon();
    @(posedge clk); #1;
    start = 1'b1;
    k_len = 4'd8;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      op_valid = 1'b1;
      a_vec    = 8'(1 << k);
      b_vec    = 8'(1 << k);
      @(posedge clk); #1;
    end
    op_valid = 1'b0;
    a_vec    = '0;
    b_vec    = '0;
    check("abort_busy_before", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_outputs_async", out_snapshot(), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (FLUSH_CYC_DEF + DRAIN_CYC_DEF + 8) @(negedge clk);
    #1;
    check("abort_no_done", done_cnt, 32'd0);
    check("abort_no_results", q_idx.size(), 32'd0);
    run_job(vecs[0], 99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
